// File: rtl/allophone_feeder.sv
// allophone_feeder: host allophone FIFO feeding the Speech256 core load handshake
module allophone_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic [5:0]            wr_data,
    input  logic                  wr_stb,
    input  logic                  flush,
    input  logic                  ldq,
    output logic [5:0]            data_out,
    output logic                  data_stb,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err,
    output logic                  drained
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef enum logic [1:0] {IDLE, STROBE, WAIT_LOW} state_t;
    state_t state;
    logic [5:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [9:0] cnt;
    logic pending_drain;
    logic push, pop;
    assign full  = level == (DEPTH_LOG2+1)'(DEPTH);
    assign empty = level == '0;
    assign busy  = !empty || state != IDLE;
    assign pop   = state == IDLE && ldq && !empty;
    assign push  = wr_stb && !full && !flush;
    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
    // Pointers, occupancy count and the dropped-write pulse
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_stb && full && !flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
            end
        end
    end
    // Load handshake: pop on ldq, strobe once, then wait for ldq low or time out
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state         <= IDLE;
            data_out      <= '0;
            data_stb      <= 1'b0;
            cnt           <= '0;
            pending_drain <= 1'b0;
            timeout_err   <= 1'b0;
            drained       <= 1'b0;
        end else begin
            data_stb    <= 1'b0;
            timeout_err <= 1'b0;
            drained     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ldq && !empty) begin
                        data_out <= mem[rd_ptr];
                        data_stb <= 1'b1;
                        state    <= STROBE;
                    end else if (ldq && pending_drain) begin
                        drained       <= 1'b1;
                        pending_drain <= 1'b0;
                    end
                end
                STROBE: begin
                    cnt   <= 10'(TIMEOUT);
                    state <= WAIT_LOW;
                    if (empty) pending_drain <= 1'b1;
                end
                WAIT_LOW: begin
                    cnt <= cnt - 1'b1;
                    if (!ldq) state <= IDLE;
                    else if (cnt == 10'd1) timeout_err <= 1'b1;
                    else if (cnt == 10'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush || wr_stb) pending_drain <= 1'b0;
        end
    end
endmodule

// File: tb/tb_allophone_feeder.sv
// tb_allophone_feeder: directed self-checking bench for allophone_feeder
module tb_allophone_feeder;
    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic [5:0] wr_data = '0;
    logic       wr_stb = 1'b0;
    logic       flush = 1'b0;
    logic       ldq = 1'b0;
    logic [5:0] data_out;
    logic       data_stb;
    logic [4:0] level;
    logic       full, empty, busy, overflow, timeout_err, drained;
    int evals = 0;
    int fails = 0;
    int stb_cnt = 0;
    int drn_cnt = 0;
    int s0, d0;
    logic [5:0] exp_codes [3];
    allophone_feeder #(.DEPTH_LOG2(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_an(rst_an), .wr_data(wr_data), .wr_stb(wr_stb),
        .flush(flush), .ldq(ldq), .data_out(data_out), .data_stb(data_stb),
        .level(level), .full(full), .empty(empty), .busy(busy),
        .overflow(overflow), .timeout_err(timeout_err), .drained(drained)
    );
    always #5 clk = ~clk;
    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (data_stb) stb_cnt <= stb_cnt + 1;
        if (drained) drn_cnt <= drn_cnt + 1;
    end
    task automatic check(input string tag, input int obs, input int exp);
        evals++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [5:0] d);
        wr_data = d;
        wr_stb = 1'b1;
        tick();
        wr_stb = 1'b0;
    endtask
    initial begin
        exp_codes[0] = 6'h05;
        exp_codes[1] = 6'h2A;
        exp_codes[2] = 6'h3F;
        repeat (2) tick();
        check("rst_data_out", data_out, 0);
        check("rst_data_stb", data_stb, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_drained", drained, 0);
        #3 rst_an = 1'b1;
        tick();
        // basic phrase of three allophones
        wr(6'h05); check("t1_level1", level, 1);
        wr(6'h2A); check("t1_level2", level, 2);
        wr(6'h3F); check("t1_level3", level, 3);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            ldq = 1'b1;
            tick();
            check("t1_stb", data_stb, 1);
            check("t1_code", data_out, exp_codes[i]);
            check("t1_level", level, 2 - i);
            ldq = 1'b0;
            repeat (5) tick();
            check("t1_stb_low", data_stb, 0);
        end
        check("t1_no_early_drain", drn_cnt, 0);
        ldq = 1'b1;
        tick();
        check("t1_drained", drained, 1);
        tick();
        check("t1_drained_end", drained, 0);
        check("t1_stb_count", stb_cnt, 3);
        check("t1_drn_count", drn_cnt, 1);
        check("t1_idle_busy", busy, 0);
        // timeout with ldq held high
        ldq = 1'b0;
        wr(6'h11);
        wr(6'h22);
        ldq = 1'b1;
        tick();
        check("t2_stb1", data_stb, 1);
        check("t2_code1", data_out, 6'h11);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t2_win_stb", data_stb, 0);
            check("t2_win_to", timeout_err, 0);
        end
        tick();
        check("t2_timeout", timeout_err, 1);
        check("t2_to_stb", data_stb, 0);
        tick();
        check("t2_timeout_end", timeout_err, 0);
        check("t2_gap_stb", data_stb, 0);
        tick();
        check("t2_stb2", data_stb, 1);
        check("t2_code2", data_out, 6'h22);
        ldq = 1'b0;
        repeat (3) tick();
        // fill to full and overflow
        for (int i = 0; i < 16; i++) begin
            wr(6'(i));
            if (i == 14) check("t3_not_full", full, 0);
        end
        check("t3_full", full, 1);
        check("t3_level16", level, 16);
        check("t3_no_ovf", overflow, 0);
        wr(6'h30);
        check("t3_ovf", overflow, 1);
        check("t3_level_ovf", level, 16);
        tick();
        check("t3_ovf_end", overflow, 0);
        // pop and write together while full
        ldq = 1'b1;
        wr(6'h3E);
        ldq = 1'b0;
        check("t4_stb", data_stb, 1);
        check("t4_code", data_out, 0);
        check("t4_level", level, 15);
        check("t4_ovf", overflow, 1);
        wr(6'h3D);
        check("t4_level_refill", level, 16);
        check("t4_no_ovf", overflow, 0);
        check("t4_full", full, 1);
        tick();
        // flush beats write while full
        flush = 1'b1;
        wr(6'h2F);
        flush = 1'b0;
        check("t5_flush_level", level, 0);
        check("t5_flush_ovf", overflow, 0);
        tick();
        for (int i = 1; i <= 4; i++) wr(6'(i));
        check("t5_level4", level, 4);
        ldq = 1'b1;
        tick();
        check("t5_stb", data_stb, 1);
        check("t5_code", data_out, 1);
        tick();
        flush = 1'b1;
        wr(6'h07);
        flush = 1'b0;
        check("t5_wl_level", level, 0);
        check("t5_wl_ovf", overflow, 0);
        s0 = stb_cnt;
        d0 = drn_cnt;
        ldq = 1'b0;
        repeat (2) tick();
        ldq = 1'b1;
        repeat (5) tick();
        check("t5_no_stb", stb_cnt, s0);
        check("t5_no_drain", drn_cnt, d0);
        check("t5_empty", empty, 1);
        // asynchronous reset during a strobe
        ldq = 1'b0;
        wr(6'h15);
        ldq = 1'b1;
        tick();
        check("t6_stb", data_stb, 1);
        check("t6_code", data_out, 6'h15);
        rst_an = 1'b0;
        #1;
        check("t6_rst_stb", data_stb, 0);
        check("t6_rst_code", data_out, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_full", full, 0);
        tick();
        rst_an = 1'b1;
        ldq = 1'b0;
        tick();
        check("t6_empty", empty, 1);
        check("t6_stb_after", data_stb, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end
endmodule
